rf_write_arbiter: RTL

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// Purpose: arbitrates two register-file writeback requesters (A: ALU, B: load) onto one write port,
//          zeroing registers 1..(2**ADDR_W-1) after reset when CLEAR_ON_RESET is set.
// Latency: accepted write appears on rf_* one cycle after the valid/ready transfer; one write per cycle.
// Backpressure: ready is combinational from state, both valids and the round-robin pointer; both readies low while clearing.
module rf_write_arbiter #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_adr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_adr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_en,
  output logic [ADDR_W-1:0] rf_w_adr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic              busy
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_last_b;
  logic                r_rf_en;
  logic [ADDR_W-1:0]   r_rf_w_adr;
  logic [DATA_W-1:0]   r_rf_w_data;

  logic                w_run;
  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_sel_adr;
  logic [DATA_W-1:0]   w_sel_data;

  // Grant: a lone requester wins outright; on a tie the one not granted last time wins.
  always_comb begin
    w_run      = (r_state == S_RUN);
    w_grant_a  = w_run & a_valid & (~b_valid | r_last_b);
    w_grant_b  = w_run & b_valid & (~a_valid | ~r_last_b);
    w_xfer     = w_grant_a | w_grant_b;
    w_sel_adr  = w_grant_a ? a_adr  : b_adr;
    w_sel_data = w_grant_a ? a_data : b_data;
  end

  assign a_ready   = w_grant_a;
  assign b_ready   = w_grant_b;
  assign busy      = (r_state == S_CLEAR);
  assign rf_en     = r_rf_en;
  assign rf_w_adr  = r_rf_w_adr;
  assign rf_w_data = r_rf_w_data;

  // Control FSM: CLEAR walks the counter from 1 up to all-ones, RUN registers the granted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RST_STATE;
      r_cnt       <= ADDR_W'(1);
      r_last_b    <= 1'b1;
      r_rf_en     <= 1'b0;
      r_rf_w_adr  <= '0;
      r_rf_w_data <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          // Counter wraps to zero only after the top register has been issued.
          if (r_cnt == '0) begin
            r_state     <= S_RUN;
            r_cnt       <= ADDR_W'(1);
            r_rf_en     <= 1'b0;
            r_rf_w_adr  <= '0;
            r_rf_w_data <= '0;
          end else begin
            r_cnt       <= r_cnt + ADDR_W'(1);
            r_rf_en     <= 1'b1;
            r_rf_w_adr  <= r_cnt;
            r_rf_w_data <= '0;
          end
        end
        S_RUN: begin
          // Writes to register 0 are accepted but never reach the port.
          if (w_xfer && (w_sel_adr != '0)) begin
            r_rf_en     <= 1'b1;
            r_rf_w_adr  <= w_sel_adr;
            r_rf_w_data <= w_sel_data;
          end else begin
            r_rf_en     <= 1'b0;
            r_rf_w_adr  <= '0;
            r_rf_w_data <= '0;
          end
          if (w_xfer) begin
            r_last_b <= w_grant_b;
          end
        end
        default: begin
          r_state <= RST_STATE;
        end
      endcase
    end
  end

endmodule
